// File: rtl/boot_rom_arbiter_if.sv
// boot_rom_arbiter_if: request/grant/response bundle between the boot ROM
// arbiter (slave) and its N_MASTERS requesters (master).
//   m_req      per-master request
//   m_add      per-master byte address, master k at [32k+31:32k]
//   m_gnt      per-master grant, one-hot or zero
//   m_r_valid  per-master response valid
//   m_r_rdata  per-master response data, master k at [DW*k +: DW]
//   m_r_err    per-master response error, qualified by m_r_valid
interface boot_rom_arbiter_if #(
   parameter int N_MASTERS  = 2,
   parameter int DATA_WIDTH = 32
);
   logic [N_MASTERS-1:0]            m_req;
   logic [N_MASTERS*32-1:0]         m_add;
   logic [N_MASTERS-1:0]            m_gnt;
   logic [N_MASTERS-1:0]            m_r_valid;
   logic [N_MASTERS*DATA_WIDTH-1:0] m_r_rdata;
   logic [N_MASTERS-1:0]            m_r_err;
   modport master (
      output m_req, m_add,
      input  m_gnt, m_r_valid, m_r_rdata, m_r_err
   );
   modport slave (
      input  m_req, m_add,
      output m_gnt, m_r_valid, m_r_rdata, m_r_err
   );
endinterface

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: round-robin sharing of the single-port boot ROM with
// address range check and sticky post-boot lock.
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           master-side request/grant/response bundle (slave modport)
//   lock_i        pulse that sets the sticky lock; locked_o shows it
//   rom_cen_o     ROM chip enable, active-low
//   rom_a_o       ROM word address
//   rom_q_i       ROM read data, valid the cycle after rom_cen_o=0
module boot_rom_arbiter #(
   parameter int          N_MASTERS      = 2,
   parameter int          ROM_ADDR_WIDTH = 13,
   parameter int          DATA_WIDTH     = 32,
   parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   boot_rom_arbiter_if.slave         bus,
   input  logic                      lock_i,
   output logic                      locked_o,
   output logic                      rom_cen_o,
   output logic [ROM_ADDR_WIDTH-3:0] rom_a_o,
   input  logic [DATA_WIDTH-1:0]     rom_q_i
);
   localparam int IW = $clog2(N_MASTERS);
   logic [IW-1:0] prio, win, resp_id;
   logic          found, in_range, lock, resp_vld, resp_err;
   logic [31:0]   off;
   // Scan from prio upward, wrapping; the first requester found wins.
   always_comb begin
      win = prio;
      found = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!found && bus.m_req[(int'(prio) + i) % N_MASTERS]) begin
            found = 1'b1;
            win = IW'((int'(prio) + i) % N_MASTERS);
         end
      end
   end
   always_comb begin
      bus.m_gnt = '0;
      if (found) bus.m_gnt[win] = 1'b1;
   end
   // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
   assign off       = bus.m_add[32*win +: 32] - BASE_ADDR;
   assign in_range  = off < (32'd1 << ROM_ADDR_WIDTH);
   assign rom_cen_o = !(found && in_range && !lock);
   assign rom_a_o   = off[ROM_ADDR_WIDTH-1:2];
   assign locked_o  = lock;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio     <= '0;
         lock     <= 1'b0;
         resp_vld <= 1'b0;
         resp_id  <= '0;
         resp_err <= 1'b0;
      end else begin
         if (found) prio <= (win == IW'(N_MASTERS - 1)) ? '0 : win + 1'b1;
         if (lock_i) lock <= 1'b1;
         resp_vld <= found;
         resp_id  <= win;
         resp_err <= !in_range || lock;
      end
   end
   // Only the responding master's lanes carry anything; errors return zero data.
   always_comb begin
      bus.m_r_valid = '0;
      bus.m_r_err   = '0;
      bus.m_r_rdata = '0;
      if (resp_vld) begin
         bus.m_r_valid[resp_id] = 1'b1;
         bus.m_r_err[resp_id]   = resp_err;
         bus.m_r_rdata[DATA_WIDTH*resp_id +: DATA_WIDTH] = resp_err ? '0 : rom_q_i;
      end
   end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb_boot_rom_arbiter: directed vectors with a response scoreboard for boot_rom_arbiter.
module tb_boot_rom_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        lock_i = 1'b0;
   logic        locked_o, rom_cen_o;
   logic [10:0] rom_a_o;
   logic [31:0] rom_q_i = '0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   typedef struct {
      int          cyc;
      logic [1:0]  v;
      logic [1:0]  e;
      logic [63:0] d;
   } exp_t;
   exp_t sb[$];
   boot_rom_arbiter_if #(.N_MASTERS(2), .DATA_WIDTH(32)) bus ();
   boot_rom_arbiter #(.N_MASTERS(2), .ROM_ADDR_WIDTH(13), .DATA_WIDTH(32), .BASE_ADDR(32'h1A00_0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .lock_i(lock_i), .locked_o(locked_o),
      .rom_cen_o(rom_cen_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i)
   );
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   function automatic logic [31:0] rom_word(input logic [10:0] a);
      return (a == 11'd4) ? 32'hDEADBEEF : (32'h5A00_0000 | {21'b0, a});
   endfunction
   // ROM macro model: registered read when enabled, holds otherwise.
   always @(posedge clk_i) if (!rom_cen_o) rom_q_i <= rom_word(rom_a_o);
   task automatic chk(input string nm, input logic [63:0] exp, input logic [63:0] act);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask
   always @(negedge clk_i) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         chk("r_valid", {62'b0, sb[0].v}, {62'b0, bus.m_r_valid});
         chk("r_err", {62'b0, sb[0].e}, {62'b0, bus.m_r_err});
         chk("r_rdata", sb[0].d, bus.m_r_rdata);
         void'(sb.pop_front());
      end else if (bus.m_r_valid != 2'b00) begin
         chk("spurious_r_valid", 64'd0, {62'b0, bus.m_r_valid});
      end
   end
   task automatic step(input logic r, input logic [1:0] rq, input logic [31:0] a0, input logic [31:0] a1,
                       input logic lk, input logic [1:0] eg, input logic ecen, input logic [10:0] ea,
                       input logic eerr, input logic elk);
      logic [31:0] w;
      @(posedge clk_i);
      #1;
      rst_i = r;
      bus.m_req = rq;
      bus.m_add = {a1, a0};
      lock_i = lk;
      #3;
      chk("gnt", {62'b0, eg}, {62'b0, bus.m_gnt});
      chk("rom_cen", {63'b0, ecen}, {63'b0, rom_cen_o});
      if (!ecen) chk("rom_a", {53'b0, ea}, {53'b0, rom_a_o});
      chk("locked", {63'b0, elk}, {63'b0, locked_o});
      w = eerr ? 32'd0 : rom_word(ea);
      if (eg != 2'b00 && !r)
         sb.push_back('{cyc + 1, eg, eerr ? eg : 2'b00, eg[1] ? {w, 32'd0} : {32'd0, w}});
   endtask
   localparam logic [31:0] IDLE = 32'h0;
   initial begin
      bus.m_req = '0;
      bus.m_add = '0;
      step(1, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      step(1, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      chk("rst_r_valid", 64'd0, {62'b0, bus.m_r_valid});
      chk("rst_r_err", 64'd0, {62'b0, bus.m_r_err});
      chk("rst_r_rdata", 64'd0, bus.m_r_rdata);
      for (int i = 0; i < 10; i++) step(0, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      // single access from master 0, word 4
      step(0, 2'b01, 32'h1A00_0010, IDLE, 0, 2'b01, 0, 11'd4, 0, 0);
      step(0, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      // master 1 alone moves the pointer back to 0
      step(0, 2'b10, IDLE, 32'h1A00_0008, 0, 2'b10, 0, 11'd2, 0, 0);
      for (int i = 0; i < 6; i++)
         step(0, 2'b11, 32'h1A00_0020, 32'h1A00_0104, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 0,
              (i % 2 == 0) ? 11'd8 : 11'h41, 0, 0);
      // out of range above and below, then top word and byte-offset address
      step(0, 2'b10, IDLE, 32'h1A00_2000, 0, 2'b10, 1, 0, 1, 0);
      step(0, 2'b10, IDLE, 32'h19FF_FFFC, 0, 2'b10, 1, 0, 1, 0);
      step(0, 2'b01, 32'h1A00_1FFC, IDLE, 0, 2'b01, 0, 11'h7FF, 0, 0);
      step(0, 2'b01, 32'h1A00_0013, IDLE, 0, 2'b01, 0, 11'd4, 0, 0);
      // lock pulsed alongside a grant: that access still completes
      step(0, 2'b01, 32'h1A00_0000, IDLE, 1, 2'b01, 0, 11'd0, 0, 0);
      step(0, 2'b01, 32'h1A00_0000, IDLE, 0, 2'b01, 1, 0, 1, 1);
      step(0, 2'b11, 32'h1A00_0000, 32'h1A00_0010, 0, 2'b10, 1, 0, 1, 1);
      step(0, 2'b01, 32'h1A00_0010, IDLE, 0, 2'b01, 1, 0, 1, 1);
      // reset with prio=1: pending grant dropped, master 0 then wins
      step(1, 2'b11, 32'h1A00_0010, 32'h1A00_0104, 0, 2'b10, 1, 0, 1, 1);
      step(0, 2'b11, 32'h1A00_0010, 32'h1A00_0104, 0, 2'b01, 0, 11'd4, 0, 0);
      step(0, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b00, IDLE, IDLE, 0, 2'b00, 1, 0, 0, 0);
      chk("scoreboard_empty", 64'd0, 64'(sb.size()));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
